// File: rtl/mmu_feeder_if.sv
// rtl/mmu_feeder_if.sv - weight-row and activation-vector handshake bundle for mmu_feeder
interface mmu_feeder_if #(
    parameter int BIT_WIDTH = 8,
    parameter int SIZE      = 16
) ();
    logic                            wt_valid;
    logic                            wt_ready;
    logic [SIZE-1:0][BIT_WIDTH-1:0]  wt_row;
    logic                            act_valid;
    logic                            act_ready;
    logic                            act_last;
    logic [SIZE-1:0][BIT_WIDTH-1:0]  act_vec;

    modport master (
        output wt_valid, wt_row, act_valid, act_vec, act_last,
        input  wt_ready, act_ready
    );

    modport slave (
        input  wt_valid, wt_row, act_valid, act_vec, act_last,
        output wt_ready, act_ready
    );
endinterface

// File: rtl/mmu_feeder.sv
// rtl/mmu_feeder.sv - loads weights, then streams skewed activations into the systolic array
module mmu_feeder #(
    parameter int BIT_WIDTH = 8,
    parameter int SIZE      = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start_i,
    mmu_feeder_if.slave                    bus,
    output logic                           control_o,
    output logic [SIZE-1:0][BIT_WIDTH-1:0] wt_arr_o,
    output logic [SIZE-1:0][BIT_WIDTH-1:0] data_arr_o,
    output logic                           busy_o,
    output logic                           done_o
);
    localparam int CW  = $clog2(2 * SIZE);
    // Lane i owns i skew entries, packed triangularly: lane i starts at i*(i-1)/2.
    localparam int TRI = SIZE * (SIZE - 1) / 2;
    localparam logic [CW-1:0] ROW_LAST   = CW'(SIZE - 1);
    localparam logic [CW-1:0] FLUSH_LAST = CW'(2 * SIZE - 1);

    typedef enum logic [1:0] {IDLE, LOAD_WT, STREAM, FLUSH} state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           wt_ready_q, wt_ready_d;
    logic                           act_ready_q, act_ready_d;
    logic                           control_q, control_d;
    logic                           busy_q, busy_d;
    logic                           done_q, done_d;
    logic [SIZE-1:0][BIT_WIDTH-1:0] wt_arr_q, wt_arr_d;
    logic [SIZE-1:0][BIT_WIDTH-1:0] data_arr_q, data_arr_d;
    logic [TRI*BIT_WIDTH-1:0]       sr_q, sr_d;
    logic [SIZE-1:0][BIT_WIDTH-1:0] inj;
    logic                           wt_acc, act_acc;

    assign wt_acc  = bus.wt_valid && wt_ready_q;
    assign act_acc = bus.act_valid && act_ready_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        control_d = wt_acc;
        wt_arr_d  = wt_acc ? bus.wt_row : wt_arr_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = LOAD_WT;
                    cnt_d   = '0;
                end
            end
            LOAD_WT: begin
                if (wt_acc) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == ROW_LAST) state_d = STREAM;
                end
            end
            STREAM: begin
                if (act_acc && bus.act_last) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end
            end
            FLUSH: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == FLUSH_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        wt_ready_d  = (state_d == LOAD_WT);
        act_ready_d = (state_d == STREAM);
        busy_d      = (state_d != IDLE);
    end

    always_comb begin
        for (int i = 0; i < SIZE; i++) inj[i] = act_acc ? bus.act_vec[i] : '0;
    end

    always_comb begin
        sr_d       = '0;
        data_arr_d = '0;
        if (state_q != IDLE) begin
            data_arr_d[0] = inj[0];
            for (int i = 1; i < SIZE; i++) begin
                for (int k = 0; k < i; k++) begin
                    if (k == 0) sr_d[(i*(i-1)/2)*BIT_WIDTH +: BIT_WIDTH] = inj[i];
                    else sr_d[(i*(i-1)/2+k)*BIT_WIDTH +: BIT_WIDTH] =
                             sr_q[(i*(i-1)/2+k-1)*BIT_WIDTH +: BIT_WIDTH];
                end
                data_arr_d[i] = sr_q[(i*(i-1)/2+i-1)*BIT_WIDTH +: BIT_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wt_ready_q  <= 1'b0;
            act_ready_q <= 1'b0;
            control_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wt_arr_q    <= '0;
            data_arr_q  <= '0;
            sr_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wt_ready_q  <= wt_ready_d;
            act_ready_q <= act_ready_d;
            control_q   <= control_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            wt_arr_q    <= wt_arr_d;
            data_arr_q  <= data_arr_d;
            sr_q        <= sr_d;
        end
    end

    assign bus.wt_ready  = wt_ready_q;
    assign bus.act_ready = act_ready_q;
    assign control_o     = control_q;
    assign wt_arr_o      = wt_arr_q;
    assign data_arr_o    = data_arr_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;
endmodule
